// File: rtl/sid_bus_writer.sv
// SID register shadow with dirty tracking and a round-robin replay onto the SID chip bus.
// Optional macro SID_INIT_FLUSH_EN: reset marks every register dirty so the chip is zeroed after reset.
module sid_bus_writer #(
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned NUM_REGS = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       sid_clk,
    output logic       sid_cs,
    output logic [4:0] sid_addr,
    output logic [7:0] sid_data,
    output logic       busy
);
    localparam int unsigned CNT_W  = $clog2(CLK_DIV);
    localparam int unsigned HALF   = CLK_DIV / 2;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned P_W    = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sid_clk_q, sid_clk_d;
    logic              cs_q, cs_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic [1:0]        state_q, state_d;
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] shadow_q [NUM_REGS];
    logic [DATA_W-1:0] shadow_d [NUM_REGS];

    logic              rise_tick, fall_tick;
    logic              sel_found;
    logic [ADDR_W-1:0] sel_idx;
    logic [P_W-1:0]    probe;

    assign rise_tick = (cnt_q == CNT_W'(HALF));
    assign fall_tick = (cnt_q == '0);

    // Phase generator; sid_clk lags the count by one cycle so cs and phi2 edges coincide.
    always_comb begin
        cnt_d     = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        sid_clk_d = (cnt_q >= CNT_W'(HALF));
    end

    // First dirty register at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        probe     = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            probe = {1'b0, rr_ptr_q} + P_W'(i);
            if (probe >= P_W'(NUM_REGS)) begin
                probe = probe - P_W'(NUM_REGS);
            end
            if (!sel_found && dirty_q[probe[ADDR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = probe[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        addr_d   = addr_q;
        data_d   = data_q;
        dirty_d  = dirty_q;
        rr_ptr_d = rr_ptr_q;
        shadow_d = shadow_q;
        busy_d   = (state_q != ST_IDLE) | (|dirty_q);

        case (state_q)
            ST_IDLE: begin
                if (fall_tick && sel_found) begin
                    addr_d           = sel_idx;
                    data_d           = shadow_q[sel_idx];
                    dirty_d[sel_idx] = 1'b0;
                    rr_ptr_d         = (sel_idx == ADDR_W'(NUM_REGS - 1)) ? '0 : sel_idx + ADDR_W'(1);
                    state_d          = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rise_tick) begin
                    cs_d    = 1'b0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (fall_tick) begin
                    cs_d    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Applied after the selection clear so a same-cycle update keeps the register dirty.
        if (wr_en && (32'(wr_addr) < NUM_REGS)) begin
            shadow_d[wr_addr] = wr_data;
            dirty_d[wr_addr]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sid_clk_q <= 1'b0;
            cs_q      <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            shadow_q  <= '{default: '0};
`ifdef SID_INIT_FLUSH_EN
            dirty_q   <= '1;
`else
            dirty_q   <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            sid_clk_q <= sid_clk_d;
            cs_q      <= cs_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            shadow_q  <= shadow_d;
            dirty_q   <= dirty_d;
        end
    end

    assign sid_clk  = sid_clk_q;
    assign sid_cs   = cs_q;
    assign sid_addr = addr_q;
    assign sid_data = data_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_sid_bus_writer.sv
// Randomised and directed bench for sid_bus_writer against a timeline model of bus slots.
module tb_sid_bus_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       sid_clk, sid_cs, busy;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;

    always #5 clk = ~clk;

    sid_bus_writer #(.CLK_DIV(16), .NUM_REGS(25)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sid_clk(sid_clk), .sid_cs(sid_cs), .sid_addr(sid_addr), .sid_data(sid_data), .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: a write selected at cycle t0 (phase 0) owns the bus through t0+17, cs low t0+9..t0+16.
    int       m_t = 0;
    int       m_start = -1000;
    bit [7:0] m_shadow [25];
    bit       m_dirty [25];
    int       m_ptr = 0;
    bit       model_ok = 0;
    bit       e_clk, e_cs, e_busy;
    int       e_addr, e_data;
    bit       m_act, m_any;
    int       m_sel, m_j;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_start = -1000; m_ptr = 0;
            for (int k = 0; k < 25; k++) begin
                m_shadow[k] = 8'h00;
`ifdef SID_INIT_FLUSH_EN
                m_dirty[k] = 1'b1;
`else
                m_dirty[k] = 1'b0;
`endif
            end
            e_clk = 0; e_cs = 1; e_addr = 0; e_data = 0; e_busy = 0;
            model_ok = 1;
        end else begin
            m_act = (m_t >= m_start + 1) && (m_t <= m_start + 17);
            m_any = 0;
            for (int k = 0; k < 25; k++) if (m_dirty[k]) m_any = 1;
            e_busy = m_act || m_any;
            if ((m_t % 16) == 0 && !m_act && m_any) begin
                m_sel = -1;
                for (int k = 0; k < 25; k++) begin
                    m_j = (m_ptr + k) % 25;
                    if (m_sel < 0 && m_dirty[m_j]) m_sel = m_j;
                end
                e_addr = m_sel;
                e_data = m_shadow[m_sel];
                m_dirty[m_sel] = 0;
                m_ptr = (m_sel + 1) % 25;
                m_start = m_t;
            end
            if (wr_en && wr_addr < 25) begin
                m_shadow[wr_addr] = wr_data;
                m_dirty[wr_addr] = 1;
            end
            e_clk = (m_t % 16) >= 8;
            e_cs = !((m_t + 1 >= m_start + 9) && (m_t + 1 <= m_start + 16));
            m_t = m_t + 1;
        end
    end

    // Per-cycle comparison plus a log of observed bus writes.
    int  a_q[$], d_q[$], len_q[$], bad_q[$], rise_q[$];
    int  cyc = 0, cs_len = 0, clk_bad = 0;
    bit  prev_cs = 1, prev_clk = 0;

    always @(negedge clk) begin
        cyc++;
        if (model_ok) begin
            chk("sid_clk", int'(sid_clk), int'(e_clk));
            chk("sid_cs", int'(sid_cs), int'(e_cs));
            chk("busy", int'(busy), int'(e_busy));
            chk("sid_addr", int'(sid_addr), e_addr);
            chk("sid_data", int'(sid_data), e_data);
            if (prev_cs && !sid_cs) begin
                a_q.push_back(int'(sid_addr));
                d_q.push_back(int'(sid_data));
                cs_len = 0; clk_bad = 0;
            end
            if (!sid_cs) begin
                cs_len++;
                if (!sid_clk) clk_bad++;
            end
            if (!prev_cs && sid_cs) begin
                len_q.push_back(cs_len);
                bad_q.push_back(clk_bad);
            end
            if (!prev_clk && sid_clk) rise_q.push_back(cyc);
            prev_cs = sid_cs;
            prev_clk = sid_clk;
        end
    end

    function automatic int addr_at(input int i);
        return (i < a_q.size()) ? a_q[i] : -1;
    endfunction
    function automatic int data_at(input int i);
        return (i < d_q.size()) ? d_q[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset(input int n);
        rst = 1; wr_en = 0;
        tick(n);
        rst = 0;
    endtask
    task automatic wr(input int a, input int d);
        wr_en = 1; wr_addr = 5'(a); wr_data = 8'(d);
        tick(1);
        wr_en = 0;
    endtask
    task automatic wait_phase(input int p);
        for (int k = 0; k < 16 && (m_t % 16) != p; k++) tick(1);
    endtask
    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        tick(2);
        while (busy !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, int'(busy), 0);
        tick(2);
    endtask
    task automatic wait_cs_low(input string name);
        int k = 0;
        while (sid_cs !== 1'b0 && k < 100) begin
            tick(1);
            k++;
        end
        chk(name, int'(sid_cs), 0);
    endtask
    task automatic clear_logs();
        a_q.delete(); d_q.delete(); len_q.delete(); bad_q.delete(); rise_q.delete();
    endtask

    initial begin
        // Reset and idle
        do_reset(3);
        clear_logs();
`ifdef SID_INIT_FLUSH_EN
        wait_idle("t1_flush_drain", 2000);
        chk("t1_flush_count", a_q.size(), 25);
        for (int i = 0; i < 25; i++) begin
            chk("t1_flush_addr", addr_at(i), i);
            chk("t1_flush_data", data_at(i), 0);
        end
`else
        tick(200);
        chk("t1_no_cs", a_q.size(), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_clk_rises", int'(rise_q.size() >= 12), 1);
        if (rise_q.size() >= 2)
            chk("t1_clk_period", rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2], 16);
`endif

        // Single write to the top register
        clear_logs();
        wr(24, 8'h0F);
        wait_idle("t2_drain", 500);
        chk("t2_count", a_q.size(), 1);
        chk("t2_addr", addr_at(0), 8'h18);
        chk("t2_data", data_at(0), 8'h0F);
        chk("t2_cs_len", (len_q.size() > 0) ? len_q[0] : -1, 8);
        chk("t2_cs_clk_low", (bad_q.size() > 0) ? bad_q[0] : -1, 0);

        // Round-robin ordering
        do_reset(1);
        clear_logs();
        wait_phase(1);
        wr(5, 8'hAA);
        wr(3, 8'h55);
        wait_idle("t3_drain_a", 500);
        chk("t3_first_addr", addr_at(0), 3);
        chk("t3_first_data", data_at(0), 8'h55);
        chk("t3_second_addr", addr_at(1), 5);
        chk("t3_second_data", data_at(1), 8'hAA);
        clear_logs();
        wait_phase(1);
        wr(2, 8'h22);
        wr(22, 8'hCC);
        wait_idle("t3_drain_b", 500);
        chk("t3_wrap_first", addr_at(0), 22);
        chk("t3_wrap_second", addr_at(1), 2);

        // Coalescing
        clear_logs();
        wait_phase(1);
        wr(8'h11, 8'h11);
        tick(3);
        wr(8'h11, 8'h21);
        wait_idle("t4_drain", 500);
        chk("t4_count", a_q.size(), 1);
        chk("t4_data", data_at(0), 8'h21);

        // Out-of-range addresses, then rewrite during the strobe
        clear_logs();
        wr(25, 1); wr(26, 2); wr(31, 3);
        tick(40);
        chk("t5_ignored_count", a_q.size(), 0);
        chk("t5_ignored_busy", int'(busy), 0);
        wr(4, 8'h33);
        wait_cs_low("t5_cs_wait");
        tick(2);
        wr(4, 8'h80);
        wait_idle("t5_drain", 500);
        chk("t5_count", a_q.size(), 2);
        chk("t5_addr0", addr_at(0), 4);
        chk("t5_addr1", addr_at(1), 4);
        chk("t5_data0", data_at(0), 8'h33);
        chk("t5_data1", data_at(1), 8'h80);

        // Random traffic, including out-of-range and selection-cycle collisions
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                wr_en = 1;
                wr_addr = 5'($urandom_range(0, 31));
                wr_data = 8'($urandom);
            end else begin
                wr_en = 0;
            end
            tick(1);
        end
        wr_en = 0;
        wait_idle("t6_drain", 2000);

        // Reset during a strobe abandons the write and pending work
        clear_logs();
        wr(9, 8'h5A);
        wr(10, 8'hA5);
        wait_cs_low("t7_cs_wait");
        tick(3);
        rst = 1;
        tick(1);
        rst = 0;
        chk("t7_cs_after_rst", int'(sid_cs), 1);
        chk("t7_busy_after_rst", int'(busy), 0);
        tick(100);
        chk("t7_no_more_writes", a_q.size(), 1);
        chk("t7_busy_idle", int'(busy), 0);
        chk("t7_cs_idle", int'(sid_cs), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sid_bus_writer.md
Name: sid_bus_writer

Overview:
- Downstream stage of the SPI receiver in espSID. Holds the 25 SID register shadow values and tracks which ones have changed (dirty).
- Generates sid_clk (phi2) from clk.
- Replays each changed register onto the SID chip bus (sid_addr, sid_data, sid_cs) with SID-legal timing.
- Writes are scheduled round-robin: one bus write per two sid_clk periods.

Parameters:
- CLK_DIV, 16: clk cycles per sid_clk period. Must be even and >= 4.
- NUM_REGS, 25: number of SID registers. Valid addresses are 0..NUM_REGS-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  single-cycle register update strobe from SPI receiver
- wr_addr  in  5  register address for wr_en
- wr_data  in  8  register value for wr_en
- sid_clk  out  1  SID phi2 clock, 50% duty
- sid_cs  out  1  SID chip select, active-low
- sid_addr  out  5  SID bus address
- sid_data  out  8  SID bus data (write only)
- busy  out  1  high while any register is dirty or a bus write is in progress

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - sid_clk=0, sid_cs=1, sid_addr=0, sid_data=0, busy=0
  - divider count=0, shadow regs=0x00, dirty=0, rr_ptr=0, state=IDLE
- Reset asserted mid-write returns sid_cs to 1 on the next clk edge; no partial write is resumed.
- Phase generator:
  - cnt runs 0..CLK_DIV-1 and wraps.
  - sid_clk is registered, high when cnt >= CLK_DIV/2.
  - rise_tick is active in the cycle where cnt==CLK_DIV/2; fall_tick in the cycle where cnt==0.
- Shadow write:
  - On wr_en with wr_addr < NUM_REGS: shadow[wr_addr] <= wr_data and dirty[wr_addr] <= 1.
  - wr_addr >= NUM_REGS is ignored entirely.
  - Accepted every cycle, in any state. No backpressure.
- Selection: combinational search for the first set dirty bit, starting at rr_ptr, ascending, wrapping at NUM_REGS-1 to 0.
- FSM:
  - IDLE: on fall_tick with any dirty bit set:
    - latch sid_addr=idx and sid_data=shadow[idx], clear dirty[idx]
    - rr_ptr <= (idx+1) mod NUM_REGS
    - -> ARMED
  - ARMED: on rise_tick, sid_cs <= 0 -> STROBE.
  - STROBE: on fall_tick, sid_cs <= 1 -> HOLD.
  - HOLD: 1 clk, with addr/data unchanged -> IDLE.
- Bus timing guarantees:
  - sid_cs is low for exactly CLK_DIV/2 clk cycles, coincident with sid_clk high.
  - sid_addr/sid_data are stable from CLK_DIV/2 cycles before the cs falling edge until at least 1 clk after the cs rising edge.
  - A new selection can happen no earlier than the next fall_tick, so there are 2 sid_clk periods per write.
- Simultaneous wr_en to the index being selected in the same cycle:
  - the bus carries the pre-update shadow value;
  - dirty[idx] stays set (the set wins over the clear), so the new value is written on a later slot.
- A re-write to a dirty register before it is scheduled coalesces: one bus write with the latest value.
- busy = (state != IDLE) | (|dirty). Registered, one cycle after the cause.

Optional Feature:
- Macro: SID_INIT_FLUSH_EN.
- Defined: reset sets dirty to all ones (rr_ptr=0). After reset, the block writes 0x00 to addresses 0..NUM_REGS-1 in ascending order, silencing the chip. busy is high from the first cycle after reset until the last HOLD.
- Undefined: reset clears dirty and the chip is not touched until the first wr_en.

Test Plan (CLK_DIV=16, macro undefined unless stated):
- Hold rst 3 cycles, then release, then idle 200 cycles -> sid_cs=1 throughout, sid_clk toggles every 8 clk, busy=0. With SID_INIT_FLUSH_EN: 25 cs pulses, addr 0x00..0x18 ascending, data 0x00, busy falls after the last.
- wr_en addr=0x18 data=0x0F -> exactly one cs-low pulse of 8 clk while sid_clk=1, addr=0x18, data=0x0F stable from 8 clk before to 1 clk after the pulse, busy returns to 0.
- From reset, wr addr 5 data 0xAA then addr 3 data 0x55 within one sid_clk period -> bus order addr 3 then 5. Afterwards wr addr 2 and 22 -> order 22 then 2 (rr_ptr=6).
- wr addr 0x11 data 0x11 then addr 0x11 data 0x21 before the next fall_tick -> single bus write, data 0x21.
- wr_en with addr 25, 26 and 31 -> no cs pulse, busy stays 0. Then wr addr 4 data 0x80 during STROBE of addr 4 -> two writes to addr 4, the second with data 0x80.
- Assert rst for 1 clk while sid_cs=0 -> sid_cs=1 on the next edge, busy=0, dirty cleared, no further writes.
